mem_dump_unit: RTL and testbench
================================

Name: mem_dump_unit

Overview:
Downstream consumer of the 16-bit data memory. After the CPU halts, it walks data memory from address 0 and streams each word, MSB byte first, to the UART transmitter. This gives the debug host a post-run memory image. While busy it owns the data-memory address port through a top-level mux selected by busy; it never writes memory.

Parameters:
RAM_WIDTH, 16, data word width; must be a multiple of 8. BYTES = RAM_WIDTH/8.
RAM_ADDR_BITS, 11, data-memory address width.
DUMP_COUNT, 16, number of words dumped per run; legal range 1..2**RAM_ADDR_BITS.

Ports:
clk  input  1  system clock. Unit acts on rising edge; data memory reads on falling edge.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle request to begin a dump (CPU halt pulse).
mem_data  input  RAM_WIDTH  data-memory read data (out_data of the memory).
tx_done  input  1  UART tx-complete tick, one cycle wide.
mem_addr  output  RAM_ADDR_BITS  registered read address to data memory.
tx_start  output  1  one-cycle request to UART tx.
tx_data  output  8  byte to transmit; valid while tx_start=1 and held until tx_done.
busy  output  1  high from start acceptance until return to IDLE; drives the memory address mux select.
done  output  1  one-cycle pulse when the last byte has completed.

Behaviour:
- Reset: state=IDLE; mem_addr=0; tx_start=0; tx_data=0; busy=0; done=0; word_cnt=0; byte_idx=0. Reset mid-dump aborts immediately. No further tx_start is issued, and an in-flight UART byte is not tracked.
- Counters: word_cnt is RAM_ADDR_BITS+1 bits wide, so DUMP_COUNT=2**RAM_ADDR_BITS terminates without wrap. mem_addr = word_cnt[RAM_ADDR_BITS-1:0]. byte_idx counts 0..BYTES-1.
- IDLE: busy=0. When start=1: word_cnt<=0, mem_addr<=0, byte_idx<=0, go to FETCH.
- FETCH: lasts exactly 1 cycle. mem_addr has been stable since the entering edge, and memory updates mem_data on the intervening falling edge. On exit, word_reg<=mem_data, then go to SEND.
- SEND: lasts 1 cycle. tx_start=1 and tx_data = byte byte_idx of word_reg, MSB byte first. Go to WAIT_TX.
- WAIT_TX: tx_start=0 and tx_data is held. Stay until tx_done=1, then:
  - if byte_idx<BYTES-1: byte_idx++, go to SEND;
  - else if word_cnt==DUMP_COUNT-1: go to DONE;
  - else: word_cnt++, mem_addr++, byte_idx<=0, go to FETCH.
- DONE: lasts 1 cycle. done=1, busy still 1. Go to IDLE.
- Latency:
  - start sampled at edge N gives tx_start high in cycle N+2.
  - tx_done at edge M gives the next tx_start at M+1 for a same-word byte, or M+2 for a new word.
  - Final tx_done at edge M gives done high in cycle M+1 and busy=0 from M+2.
- start while busy (any state except IDLE) is ignored and never queued.
- tx_done outside WAIT_TX is ignored, including tx_done coincident with tx_start.
- busy is combinationally (state!=IDLE), and every transition above is on the rising edge.

Decomposition:
- Shared package/include holds the state encoding localparams (IDLE, FETCH, SEND, WAIT_TX, DONE) and the BYTES derivation, so the top-level debug unit and bench decode the same values.
- One natural sub-module: dump_byte_sel. It selects the byte byte_idx from word_reg, MSB first, parameterised by RAM_WIDTH.
- The FSM and counters stay in mem_dump_unit.

Test Plan:
1. Defaults; preload mem[0]=16'h1234, mem[1]=16'hABCD; DUMP_COUNT=2; UART model returns tx_done 10 cycles after each tx_start.
   -> tx_data sequence 8'h12, 8'h34, 8'hAB, 8'hCD.
   -> First tx_start exactly 2 cycles after start.
   -> done pulses once, 1 cycle after the 4th tx_done.
2. DUMP_COUNT=2048; mem[i]=i.
   -> 4096 bytes sent.
   -> Last pair is 8'h07, 8'hFF.
   -> mem_addr never wraps to 0 before done.
3. start pulsed again in WAIT_TX of the first byte, and a stray tx_done in FETCH.
   -> Byte stream identical to test 1.
   -> Exactly one done pulse.
4. reset asserted in WAIT_TX of the third byte.
   -> Next cycle: IDLE, busy=0, tx_start=0, mem_addr=0.
   -> Later tx_done is ignored.
   -> A fresh start restarts the dump at 8'h12.
5. tx_done held low for 1000 cycles.
   -> Unit stays in WAIT_TX with tx_data stable and no repeated tx_start.
6. Back-to-back runs: start again 1 cycle after busy falls.
   -> Second run is accepted and produces an identical byte stream.

Source files
------------

// File: rtl/mem_dump_unit_pkg.sv
// Shared definitions for the post-halt memory dump unit: FSM state encoding
// and the bytes-per-word derivation used by the top level and the byte selector.
package mem_dump_unit_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    SEND    = 3'd2,
    WAIT_TX = 3'd3,
    DONE    = 3'd4
  } dump_state_t;

  function automatic int bytesPerWord(input int ramWidth);
    return ramWidth / 8;
  endfunction

  // A one-byte word still needs a one-bit index register.
  function automatic int byteIdxWidth(input int nBytes);
    return (nBytes > 1) ? $clog2(nBytes) : 1;
  endfunction

endpackage

// File: rtl/mem_dump_unit_byte_sel.sv
// Picks byte i_idx out of a memory word, counting from the most significant
// byte, so a word goes out on the UART in big-endian order.
module dump_byte_sel
  import mem_dump_unit_pkg::*;
#(
  parameter int RAM_WIDTH = 16,
  parameter int IDX_W     = 1
)(
  input  logic [RAM_WIDTH-1:0] i_word,
  input  logic [IDX_W-1:0]     i_idx,
  output logic [7:0]           o_byte
);

  localparam int BYTES = bytesPerWord(RAM_WIDTH);

  always_comb begin
    o_byte = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (i_idx == IDX_W'(b)) begin
        o_byte = i_word[RAM_WIDTH-1-8*b -: 8];
      end
    end
  end

endmodule

// File: rtl/mem_dump_unit.sv
// Walks data memory from address 0 after a CPU halt and streams each word,
// MSB byte first, to the UART transmitter as a post-run memory image.
module mem_dump_unit
  import mem_dump_unit_pkg::*;
#(
  parameter int RAM_WIDTH     = 16,
  parameter int RAM_ADDR_BITS = 11,
  parameter int DUMP_COUNT    = 16
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [RAM_WIDTH-1:0]     mem_data,
  input  logic                     tx_done,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     busy,
  output logic                     done
);

  localparam int BYTES = bytesPerWord(RAM_WIDTH);
  localparam int IDX_W = byteIdxWidth(BYTES);
  localparam int CNT_W = RAM_ADDR_BITS + 1;
  localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DUMP_COUNT - 1);

  dump_state_t r_state;
  dump_state_t w_next_state;

  // One extra counter bit lets a full-memory dump finish without wrapping.
  logic [CNT_W-1:0]     r_word_cnt;
  logic [IDX_W-1:0]     r_byte_idx;
  logic [RAM_WIDTH-1:0] r_word;
  logic [7:0]           w_tx_byte;
  logic                 w_last_byte;
  logic                 w_last_word;

  assign w_last_byte = (r_byte_idx == LAST_BYTE);
  assign w_last_word = (r_word_cnt == LAST_WORD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = FETCH;
      FETCH:   w_next_state = SEND;
      SEND:    w_next_state = WAIT_TX;
      WAIT_TX: begin
        if (tx_done) begin
          if (!w_last_byte)     w_next_state = SEND;
          else if (w_last_word) w_next_state = DONE;
          else                  w_next_state = FETCH;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Memory reads on the falling edge, so mem_data is valid by the end of FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word_cnt <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_word_cnt <= '0;
            r_byte_idx <= '0;
          end
        end
        FETCH: r_word <= mem_data;
        WAIT_TX: begin
          if (tx_done) begin
            if (!w_last_byte) begin
              r_byte_idx <= r_byte_idx + IDX_W'(1);
            end else if (!w_last_word) begin
              r_word_cnt <= r_word_cnt + CNT_W'(1);
              r_byte_idx <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  dump_byte_sel #(
    .RAM_WIDTH (RAM_WIDTH),
    .IDX_W     (IDX_W)
  ) u_byte_sel (
    .i_word (r_word),
    .i_idx  (r_byte_idx),
    .o_byte (w_tx_byte)
  );

  assign mem_addr = r_word_cnt[RAM_ADDR_BITS-1:0];
  assign tx_data  = w_tx_byte;
  assign tx_start = (r_state == SEND);
  assign done     = (r_state == DONE);
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_mem_dump_unit.sv
// Bench for mem_dump_unit: a two-word dump driven with randomized memory and
// UART latency, plus a full 2048-word dump on a second instance.
module tb_mem_dump_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Instance A: two-word dump
  logic        resetA, startA;
  logic [15:0] memDataA;
  wire         txDoneA;
  logic [10:0] memAddrA;
  logic        txStartA, busyA, doneA;
  logic [7:0]  txDataA;
  logic [15:0] memA [0:2047];

  // Instance B: whole-memory dump
  logic        resetB, startB;
  logic [15:0] memDataB;
  logic        txDoneB;
  logic [10:0] memAddrB;
  logic        txStartB, busyB, doneB;
  logic [7:0]  txDataB;
  logic [15:0] memB [0:2047];

  mem_dump_unit #(.RAM_WIDTH(16), .RAM_ADDR_BITS(11), .DUMP_COUNT(2)) dutA (
    .clk(clk), .reset(resetA), .start(startA), .mem_data(memDataA), .tx_done(txDoneA),
    .mem_addr(memAddrA), .tx_start(txStartA), .tx_data(txDataA), .busy(busyA), .done(doneA)
  );

  mem_dump_unit #(.RAM_WIDTH(16), .RAM_ADDR_BITS(11), .DUMP_COUNT(2048)) dutB (
    .clk(clk), .reset(resetB), .start(startB), .mem_data(memDataB), .tx_done(txDoneB),
    .mem_addr(memAddrB), .tx_start(txStartB), .tx_data(txDataB), .busy(busyB), .done(doneB)
  );

  // Data memories read on the falling edge
  always @(negedge clk) memDataA <= memA[memAddrA];
  always @(negedge clk) memDataB <= memB[memAddrB];

  // UART model A: tx_done uartDelay cycles after each tx_start, unless held
  int   uartDelay = 10;
  bit   uartHold = 1'b0;
  bit   strayDone = 1'b0;
  logic uartPulse = 1'b0;
  int   uartCnt = 0;
  int   lastTxDoneCyc = 0;
  assign txDoneA = uartPulse | strayDone;

  initial begin
    forever begin
      @(posedge clk); #2;
      uartPulse = 1'b0;
      if (uartCnt > 0) begin
        uartCnt--;
        if (uartCnt == 0) begin
          uartPulse = 1'b1;
          lastTxDoneCyc = cyc;
        end
      end
      if (txStartA && !uartHold) uartCnt = uartDelay;
    end
  end

  // Monitor A: records the byte stream, first tx_start cycle and done pulses
  logic [7:0] gotQ [$];
  logic [7:0] expQ [$];
  int firstStartCyc = 0;
  int startCyc = 0;
  int doneCnt = 0;
  int doneCyc = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (txStartA) begin
        if (gotQ.size() == 0) firstStartCyc = cyc;
        gotQ.push_back(txDataA);
      end
      if (doneA) begin
        doneCnt++;
        doneCyc = cyc;
      end
    end
  end

  // Instance B: monitor checks each byte against word k/2 = k/2, UART answers next cycle
  int   kB = 0;
  int   bErr = 0;
  int   doneCntB = 0;
  bit   wrapB = 1'b0;
  bit   sawNonZeroB = 1'b0;
  logic [15:0] lastPairB = '0;
  int   uartCntB = 0;

  initial begin
    txDoneB = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (txStartB) begin
        logic [15:0] wordExp;
        logic [7:0]  byteExp;
        wordExp = 16'(kB / 2);
        byteExp = (kB % 2 == 0) ? wordExp[15:8] : wordExp[7:0];
        if (txDataB !== byteExp) bErr++;
        lastPairB = {lastPairB[7:0], txDataB};
        kB++;
      end
      if (busyB && doneCntB == 0) begin
        if (memAddrB != 11'd0) sawNonZeroB = 1'b1;
        else if (sawNonZeroB) wrapB = 1'b1;
      end
      if (doneB) doneCntB++;
      #1;
      txDoneB = 1'b0;
      if (uartCntB > 0) begin
        uartCntB--;
        if (uartCntB == 0) txDoneB = 1'b1;
      end
      if (txStartB) uartCntB = 1;
    end
  end

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus();
    startA = 1'b1;
    startCyc = cyc;
    tick();
    startA = 1'b0;
  endtask

  // Reference image: first two words, MSB byte first
  task automatic buildExpected();
    expQ.delete();
    for (int w = 0; w < 2; w++) begin
      expQ.push_back(memA[w] / 256);
      expQ.push_back(memA[w] % 256);
    end
  endtask

  task automatic waitDoneA(input int budget);
    int n = 0;
    while (doneCnt == 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("done_seen", 32'(doneCnt != 0), 1);
  endtask

  task automatic compareStream(input string tag);
    checkOutput({tag, "_bytes"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), gotQ[i], expQ[i]);
  endtask

  // mode 0 plain run; 1 stray tx_done in FETCH/SEND and start in WAIT_TX; 2 UART stalls on byte 0
  task automatic runA(input string tag, input int mode);
    int bad;
    int n;
    gotQ.delete();
    doneCnt = 0;
    buildExpected();
    applyStimulus();
    if (mode == 1) begin
      strayDone = 1'b1;
      tick();
      tick();
      strayDone = 1'b0;
      startA = 1'b1;
      tick();
      startA = 1'b0;
    end
    if (mode == 2) begin
      n = 0;
      while (gotQ.size() == 0 && n < 20) begin tick(); n++; end
      tick();
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
        if (txDataA !== expQ[0] || busyA !== 1'b1 || txStartA !== 1'b0) bad++;
        tick();
      end
      checkOutput({tag, "_stall_stable"}, bad, 0);
      checkOutput({tag, "_stall_no_repeat"}, gotQ.size(), 1);
      uartHold = 1'b0;
      strayDone = 1'b1;
      tick();
      strayDone = 1'b0;
    end
    waitDoneA(3000);
    checkOutput({tag, "_busy_in_done"}, busyA, 1);
    checkOutput({tag, "_done_latency"}, doneCyc - lastTxDoneCyc, 1);
    checkOutput({tag, "_first_tx_latency"}, firstStartCyc - startCyc, 2);
    tick();
    checkOutput({tag, "_busy_after_done"}, busyA, 0);
    checkOutput({tag, "_done_after"}, doneA, 0);
    compareStream(tag);
  endtask

  initial begin
    int n;
    resetA = 1'b1;
    resetB = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      memA[i] = 16'(i * 3 + 1);
      memB[i] = 16'(i);
    end
    memA[0] = 16'h1234;
    memA[1] = 16'hABCD;
    repeat (3) tick();
    resetA = 1'b0;
    resetB = 1'b0;
    tick();
    checkOutput("rst_busy", busyA, 0);
    checkOutput("rst_tx_start", txStartA, 0);
    checkOutput("rst_mem_addr", memAddrA, 0);
    checkOutput("rst_tx_data", txDataA, 0);
    checkOutput("rst_done", doneA, 0);

    // Fixed image 1234/ABCD with a 10-cycle UART
    uartDelay = 10;
    runA("t1", 0);
    repeat (5) tick();
    checkOutput("t1_single_done", doneCnt, 1);

    // Disturbances: stray tx_done and a repeated start
    runA("t3", 1);
    repeat (5) tick();
    checkOutput("t3_single_done", doneCnt, 1);

    // Reset during WAIT_TX of the third byte
    gotQ.delete();
    applyStimulus();
    n = 0;
    while (gotQ.size() < 3 && n < 100) begin tick(); n++; end
    checkOutput("t4_reached_byte3", gotQ.size(), 3);
    tick();
    resetA = 1'b1;
    tick();
    resetA = 1'b0;
    checkOutput("t4_busy", busyA, 0);
    checkOutput("t4_tx_start", txStartA, 0);
    checkOutput("t4_mem_addr", memAddrA, 0);
    repeat (15) tick();
    checkOutput("t4_late_done_ignored", gotQ.size(), 3);
    checkOutput("t4_still_idle", busyA, 0);
    runA("t4_restart", 0);

    // UART stalled for 1000 cycles on the first byte
    memA[0] = 16'($urandom);
    memA[1] = 16'($urandom);
    uartHold = 1'b1;
    runA("t5", 2);

    // Random images and UART latencies
    for (int r = 0; r < 4; r++) begin
      memA[0] = 16'($urandom);
      memA[1] = 16'($urandom);
      uartDelay = $urandom_range(1, 12);
      runA($sformatf("rnd%0d", r), 0);
    end

    // Back-to-back: second start in the first idle cycle
    memA[0] = 16'($urandom);
    memA[1] = 16'($urandom);
    uartDelay = $urandom_range(1, 6);
    runA("t6a", 0);
    runA("t6b", 0);

    // Full 2048-word dump on instance B
    startB = 1'b1;
    tick();
    startB = 1'b0;
    n = 0;
    while (doneCntB == 0 && n < 20000) begin tick(); n++; end
    checkOutput("t2_done_seen", 32'(doneCntB != 0), 1);
    repeat (4) tick();
    checkOutput("t2_byte_count", kB, 4096);
    checkOutput("t2_last_pair", lastPairB, 16'h07FF);
    checkOutput("t2_byte_errors", bErr, 0);
    checkOutput("t2_addr_wrap", wrapB, 0);
    checkOutput("t2_single_done", doneCntB, 1);
    checkOutput("t2_idle", busyB, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
